// File: rtl/mrnaiso_valve_sequencer.sv
// Pneumatic valve sequencer for the mRNA isolation bank: cells, beads, lysis, mix, separate, collect.
// Optional FLUSH phase after COLLECT is built only when MRNAISO_FLUSH_EN is defined.
module mrnaiso_valve_sequencer #(
  parameter logic [15:0] T_CELLS   = 16'd16,
  parameter logic [15:0] T_BEADS   = 16'd16,
  parameter logic [15:0] T_LYSIS   = 16'd32,
  parameter logic [15:0] PUMP_DIV  = 16'd4,
  parameter logic [15:0] MIX_REVS  = 16'd8,
  parameter logic [15:0] T_SEP     = 16'd32,
  parameter logic [15:0] T_COLLECT = 16'd16,
  parameter logic [15:0] T_FLUSH   = 16'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        hold,
  output logic [12:0] ctrl_closed,
  output logic [12:0] flush,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [2:0]  phase
);

  typedef enum logic [2:0] {
    S_IDLE, S_CELLS, S_BEADS, S_LYSIS, S_MIX, S_SEP, S_COLLECT, S_FLUSH
  } state_t;

  localparam int unsigned PD_EFF   = (PUMP_DIV == 16'd0) ? 1 : int'(PUMP_DIV);
  localparam int unsigned MR_EFF   = (MIX_REVS == 16'd0) ? 1 : int'(MIX_REVS);
  localparam logic [23:0] D_MIX    = 24'(6 * PD_EFF * MR_EFF);
  localparam logic [15:0] PD_RLD   = (PUMP_DIV == 16'd0) ? 16'd1 : PUMP_DIV;

  function automatic logic [23:0] eff(input logic [15:0] t);
    return (t == 16'd0) ? 24'd1 : {8'd0, t};
  endfunction

  function automatic logic [23:0] dur_of(input state_t s);
    case (s)
      S_CELLS:   return eff(T_CELLS);
      S_BEADS:   return eff(T_BEADS);
      S_LYSIS:   return eff(T_LYSIS);
      S_MIX:     return D_MIX;
      S_SEP:     return eff(T_SEP);
      S_COLLECT: return eff(T_COLLECT);
      S_FLUSH:   return eff(T_FLUSH);
      default:   return 24'd1;
    endcase
  endfunction

  // {pump3,pump2,pump1} closed bits for each peristaltic step
  function automatic logic [2:0] pump_pat(input logic [2:0] step);
    case (step)
      3'd0:    return 3'b110;
      3'd1:    return 3'b100;
      3'd2:    return 3'b101;
      3'd3:    return 3'b001;
      3'd4:    return 3'b011;
      3'd5:    return 3'b010;
      default: return 3'b110;
    endcase
  endfunction

  function automatic logic [12:0] ctrl_of(input state_t s, input logic [2:0] step);
    logic [12:0] v;
    v = 13'h1FFF;
    case (s)
      S_CELLS:   v[12:11] = 2'b00;
      S_BEADS:   begin v[10] = 1'b0; v[8] = 1'b0; end
      S_LYSIS:   v[2:1] = 2'b00;
      S_MIX:     v[6:4] = pump_pat(step);
      S_SEP:     begin v[9] = 1'b0; v[7] = 1'b0; end
      S_COLLECT: begin v[3] = 1'b0; v[0] = 1'b0; end
      S_FLUSH:   v = 13'h0000;
      default:   ;
    endcase
    return v;
  endfunction

  function automatic state_t next_of(input state_t s);
    case (s)
      S_IDLE:    return S_CELLS;
      S_CELLS:   return S_BEADS;
      S_BEADS:   return S_LYSIS;
      S_LYSIS:   return S_MIX;
      S_MIX:     return S_SEP;
      S_SEP:     return S_COLLECT;
`ifdef MRNAISO_FLUSH_EN
      S_COLLECT: return S_FLUSH;
`else
      S_COLLECT: return S_IDLE;
`endif
      default:   return S_IDLE;
    endcase
  endfunction

  state_t      r_state;
  logic [23:0] r_cnt;
  logic [15:0] r_div;
  logic [2:0]  r_step;
  logic [12:0] r_ctrl;
  logic        r_busy;
  logic        r_done;
  logic        r_aborted;
  logic        r_start;
`ifdef MRNAISO_FLUSH_EN
  logic [12:0] r_flush;
`endif

  state_t      w_target;
  logic        w_idle;
  logic        w_go;
  logic [2:0]  w_step_nxt;

  assign w_idle     = (r_state == S_IDLE);
  assign w_target   = next_of(r_state);
  assign w_go       = w_idle ? (r_start & ~abort) : (~abort & ~hold & (r_cnt <= 24'd1));
  assign w_step_nxt = (r_step == 3'd5) ? 3'd0 : r_step + 3'd1;

  // start is registered once in IDLE, so LOAD_CELLS begins the edge after it is sampled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 24'd1;
      r_div     <= PD_RLD;
      r_step    <= 3'd0;
      r_ctrl    <= 13'h1FFF;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_start   <= 1'b0;
`ifdef MRNAISO_FLUSH_EN
      r_flush   <= 13'h0000;
`endif
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_start   <= w_idle & start & ~abort;
      if (!w_idle && abort) begin
        r_state   <= S_IDLE;
        r_ctrl    <= 13'h1FFF;
        r_busy    <= 1'b0;
        r_aborted <= 1'b1;
`ifdef MRNAISO_FLUSH_EN
        r_flush   <= 13'h0000;
`endif
      end else if (w_go) begin
        r_state <= w_target;
        r_cnt   <= dur_of(w_target);
        r_ctrl  <= ctrl_of(w_target, 3'd0);
        r_busy  <= (w_target != S_IDLE);
        r_done  <= (w_target == S_IDLE);
        r_step  <= 3'd0;
        r_div   <= PD_RLD;
`ifdef MRNAISO_FLUSH_EN
        r_flush <= (w_target == S_FLUSH) ? 13'h1FFF : 13'h0000;
`endif
      end else if (!w_idle && !hold) begin
        r_cnt <= r_cnt - 24'd1;
        if (r_state == S_MIX) begin
          if (r_div <= 16'd1) begin
            r_div  <= PD_RLD;
            r_step <= w_step_nxt;
            r_ctrl <= ctrl_of(S_MIX, w_step_nxt);
          end else begin
            r_div <= r_div - 16'd1;
          end
        end
      end
    end
  end

  assign ctrl_closed = r_ctrl;
  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign phase       = r_state;
`ifdef MRNAISO_FLUSH_EN
  assign flush       = r_flush;
`else
  assign flush       = 13'h0000;
`endif

endmodule
